timeout_counter: RTL
====================

# timeout_counter

Parametrised, clocked timeout counter that generalises the team's 3-bit "increment until TimeOut, then return to Zero" logic. Supports configurable width and terminal value, wrap or one-shot mode, run control, mid-count load, and a registered expiry handshake. Sits beside protocol/control FSMs as their watchdog/interval timer: they start it, optionally reload it, and consume TimeOut / Expired.

## Interface
Parameters:
- WIDTH, 3, counter width in bits (≥ 2)
- TIMEOUT, 6, terminal value; 0 ≤ TIMEOUT ≤ 2^WIDTH−1
- PRESCALE, 4, cycles per count advance; ≥ 1; used only with TIMEOUT_COUNTER_PRESCALE_EN

Ports:
- Clock  input  1  single clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  begin counting from IDLE (or from EXPIRED together with Ack)
- Stop  input  1  abort to IDLE; Time holds its value
- Mode  input  1  0 = wrap, 1 = one-shot; sampled only when Start is accepted
- Load  input  1  in RUN, or together with an accepted Start, replace Time with LoadValue
- LoadValue  input  WIDTH  load value; values > TIMEOUT are clamped to TIMEOUT
- Ack  input  1  acknowledge expiry; EXPIRED → IDLE
- Time  output  WIDTH  current count (registered)
- TimeOut  output  1  one-cycle registered pulse per terminal event
- Expired  output  1  high while in EXPIRED
- Busy  output  1  high while in RUN

## Operation
- States: IDLE, RUN, EXPIRED. Reset → IDLE; Time=0, TimeOut=0, Expired=0, Busy=0.
- Priority each edge: Reset > Stop > Ack > Start > Load > advance.
- IDLE: Time holds. Start → RUN; Time := 0, or clamp(LoadValue) if Load is also high. Latch Mode.
- RUN, advance: if Time ≠ TIMEOUT, Time := Time+1. If Time == TIMEOUT, assert TimeOut next cycle; wrap mode: Time := 0, stay in RUN; one-shot: Time holds TIMEOUT, go to EXPIRED.
- RUN, Load: Time := clamp(LoadValue), no advance that edge, no TimeOut even if loaded value equals TIMEOUT.
- RUN: Start is ignored; Mode changes are ignored until the next accepted Start.
- Stop in RUN or EXPIRED → IDLE; Time holds; no TimeOut.
- EXPIRED: Time = TIMEOUT. Ack → IDLE, Time := 0. Ack+Start on the same edge → RUN, Time := 0 (or loaded), with the new Mode. Start alone is ignored.
- TIMEOUT = 0: every advance is terminal; wrap mode pulses TimeOut on every advance.
- Arithmetic is WIDTH-bit unsigned; Time never exceeds TIMEOUT, so no natural overflow occurs.

## Timing
- Outputs are registered; no combinational input→output paths.
- Start accepted at edge k → Busy=1, Time=0 after edge k; Time=1 after edge k+1.
- Wrap period = TIMEOUT+1 advances. With defaults, Start at edge 0 gives Time=6 after edge 6. Edge 7 sets Time=0 and TimeOut=1 for that one cycle.
- One-shot: TimeOut and Expired both rise after the terminal edge; Busy falls on the same edge.
- TimeOut is never high for two consecutive cycles unless TIMEOUT=0 in wrap mode.
- Reset mid-RUN/EXPIRED: all outputs return to reset values on that edge; a pending TimeOut is dropped.

## Configuration
- TIMEOUT_COUNTER_PRESCALE_EN defined: an internal prescaler produces an advance once every PRESCALE RUN cycles. The prescaler clears on Reset, accepted Start, Load, Stop and each terminal event. Wrap period = (TIMEOUT+1)·PRESCALE cycles.
- Undefined: an advance occurs every RUN cycle; PRESCALE is ignored; no prescaler logic is synthesised.

## Test plan
- Defaults, wrap mode, Start pulse → Time steps 0,1,…,6,0; TimeOut high exactly once per 7 cycles; Busy stays 1.
- One-shot mode → Time reaches 6 and holds; Expired=1, Busy=0, a single TimeOut. Ack → Time=0, IDLE. Ack+Start → restart at 0.
- Load in RUN with LoadValue=5 → Time=5 next cycle, 6, then wrap. LoadValue=7 → clamped to 6, with no TimeOut on the load edge.
- Stop at Time=3 → IDLE with Time=3 held. Simultaneous Stop+Load → Stop wins. Start in RUN → ignored.
- Reset asserted while Time=6 and TimeOut is pending → Time=0, TimeOut=0, Expired=0, Busy=0 next cycle.
- With TIMEOUT_COUNTER_PRESCALE_EN and PRESCALE=4 → Time advances every 4 cycles; TimeOut every 28 cycles. WIDTH=8, TIMEOUT=255 → wraps 255→0 without error.

Source files
------------

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - parametrised watchdog/interval timeout counter (optional prescaler via TIMEOUT_COUNTER_PRESCALE_EN)
module timeout_counter #(
   parameter int WIDTH    = 3,
   parameter int TIMEOUT  = 6,
   parameter int PRESCALE = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             mode_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   input  logic             ack_i,
   output logic [WIDTH-1:0] time_o,
   output logic             timeout_o,
   output logic             expired_o,
   output logic             busy_o
);

   localparam logic [1:0]       ST_IDLE    = 2'd0;
   localparam logic [1:0]       ST_RUN     = 2'd1;
   localparam logic [1:0]       ST_EXPIRED = 2'd2;
   localparam logic [WIDTH-1:0] TERM       = WIDTH'(TIMEOUT);

   // Reject parameter sets the counter cannot honour at elaboration time
   if (WIDTH < 2 || PRESCALE < 1 || TIMEOUT < 0 || TIMEOUT > (2 ** WIDTH) - 1) begin : g_bad_params
      $error("timeout_counter: illegal WIDTH/TIMEOUT/PRESCALE");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] time_q, time_d;
   logic             timeout_q, timeout_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] load_clamped;
   logic             advance;

   // Out-of-range load values saturate at the terminal value so Time never exceeds it
   assign load_clamped = (load_value_i > TERM) ? TERM : load_value_i;

`ifdef TIMEOUT_COUNTER_PRESCALE_EN
   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;

   assign advance = (pre_q == PRE_LAST);

   // Count RUN cycles between advances; restart on stop, load, every advance and outside RUN
   always_comb begin
      pre_d = pre_q + 1'b1;
      if (state_q != ST_RUN || stop_i || load_i || advance) begin
         pre_d = '0;
      end
   end

   // Prescaler register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign advance = 1'b1;
`endif

   // Next-state selection in priority order Stop > Ack > Start > Load > advance
   always_comb begin
      state_d   = state_q;
      time_d    = time_q;
      mode_d    = mode_q;
      timeout_d = 1'b0;
      if (stop_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d = ST_RUN;
                  mode_d  = mode_i;
                  time_d  = load_i ? load_clamped : '0;
               end
            end
            ST_EXPIRED: begin
               if (ack_i) begin
                  if (start_i) begin
                     state_d = ST_RUN;
                     mode_d  = mode_i;
                     time_d  = load_i ? load_clamped : '0;
                  end else begin
                     state_d = ST_IDLE;
                     time_d  = '0;
                  end
               end
            end
            ST_RUN: begin
               if (load_i) begin
                  time_d = load_clamped;
               end else if (advance) begin
                  if (time_q == TERM) begin
                     timeout_d = 1'b1;
                     if (mode_q) begin
                        state_d = ST_EXPIRED;
                     end else begin
                        time_d = '0;
                     end
                  end else begin
                     time_d = time_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, count and expiry pulse registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         time_q    <= '0;
         timeout_q <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         timeout_q <= timeout_d;
         mode_q    <= mode_d;
      end
   end

   assign time_o    = time_q;
   assign timeout_o = timeout_q;
   assign expired_o = (state_q == ST_EXPIRED);
   assign busy_o    = (state_q == ST_RUN);

endmodule
